// File: rtl/doom_pkg.sv
// Shared Doom datapath constants: game-state encoding, one-hot directions, tick rate.
// No logic of its own; the direction helpers are pure combinational functions.
package doom_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_HIT  = 2'd2;
    localparam logic [1:0] ST_OVER = 2'd3;

    localparam logic [2:0] DIR_L = 3'b100;
    localparam logic [2:0] DIR_F = 3'b010;
    localparam logic [2:0] DIR_R = 3'b001;

    localparam int CLK_HZ   = 100_000_000;
    localparam int TICK_HZ  = 100;
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;

    // Direction index 0=left, 1=forward, 2=right; wraps right back to left.
    function automatic logic [1:0] dir_next(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    function automatic logic [2:0] dir_onehot(input logic [1:0] idx);
        case (idx)
            2'd0:    return DIR_L;
            2'd1:    return DIR_F;
            default: return DIR_R;
        endcase
    endfunction

endpackage

// File: rtl/spawn_lfsr.sv
// 8-bit Galois LFSR, x^8+x^6+x^5+x^4+1, advancing every clock from SEED.
// Free-running, registered output, no backpressure.
module spawn_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       ClkPort,
    input  logic       Reset,
    output logic [7:0] q
);

    logic [7:0] r_q;

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            r_q <= SEED;
        end else begin
            r_q <= {1'b0, r_q[7:1]} ^ (r_q[0] ? 8'hB8 : 8'h00);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/spawn_scheduler.sv
// Game-phase FSM and enemy-spawn scheduler; all outputs registered, one-cycle update latency.
// spawn_valid/spawn_dir hold until spawn_ready; the interval timer is frozen while a request waits.
module spawn_scheduler
    import doom_pkg::*;
#(
    parameter int         SPAWN_BASE      = 200,
    parameter int         SPAWN_MIN       = 50,
    parameter int         SPAWN_STEP      = 10,
    parameter int         MAX_HEALTH      = 5,
    parameter int         HIT_TICKS       = 100,
    parameter int         KILLS_PER_LEVEL = 4,
    parameter logic [7:0] LFSR_SEED       = 8'hA5
) (
    input  logic       ClkPort,
    input  logic       Reset,
    input  logic       tick,
    input  logic       start,
    input  logic [2:0] occupied,
    input  logic       enemy_attack,
    input  logic       enemy_kill,
    input  logic       spawn_ready,
    output logic       spawn_valid,
    output logic [2:0] spawn_dir,
    output logic [1:0] game_state,
    output logic [2:0] health,
    output logic [3:0] level
);

    localparam logic [10:0] BASE_W    = 11'(SPAWN_BASE);
    localparam logic [10:0] MIN_W     = 11'(SPAWN_MIN);
    localparam logic [10:0] STEP_W    = 11'(SPAWN_STEP);
    localparam logic [10:0] HIT_W     = 11'(HIT_TICKS);
    localparam logic [2:0]  HEALTH_W  = 3'(MAX_HEALTH);
    localparam logic [7:0]  KILL_LAST = 8'(KILLS_PER_LEVEL - 1);

    logic [1:0]  r_state;
    logic        r_start_q;
    logic [2:0]  r_health;
    logic [3:0]  r_level;
    logic [7:0]  r_kills;
    logic [10:0] r_interval;
    logic [10:0] r_hit_cnt;
    logic        r_spawn_valid;
    logic [2:0]  r_spawn_dir;
    logic [1:0]  r_rr_ptr;

    logic [7:0]  w_lfsr;
    logic [5:0]  w_lfsr_unused;
    logic        w_start_edge;
    logic        w_active;
    logic [1:0]  w_cand;
    logic [1:0]  w_c1;
    logic [1:0]  w_c2;
    logic [1:0]  w_idx;
    logic        w_found;
    logic [10:0] w_dec;
    logic [10:0] w_reload;

    spawn_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .ClkPort (ClkPort),
        .Reset   (Reset),
        .q       (w_lfsr)
    );

    assign w_lfsr_unused = w_lfsr[7:2];
    assign w_start_edge  = start & ~r_start_q;
    assign w_active      = (r_state == ST_PLAY) || (r_state == ST_HIT);

    // Candidate 3 defers to the round-robin pointer so no direction is starved.
    assign w_cand = (w_lfsr[1:0] == 2'd3) ? r_rr_ptr : w_lfsr[1:0];
    assign w_c1   = dir_next(w_cand);
    assign w_c2   = dir_next(w_c1);

    always_comb begin
        w_found = 1'b1;
        w_idx   = w_cand;
        if ((occupied & dir_onehot(w_cand)) == 3'b000) begin
            w_idx = w_cand;
        end else if ((occupied & dir_onehot(w_c1)) == 3'b000) begin
            w_idx = w_c1;
        end else if ((occupied & dir_onehot(w_c2)) == 3'b000) begin
            w_idx = w_c2;
        end else begin
            w_found = 1'b0;
        end
    end

    assign w_dec    = 11'(r_level) * STEP_W;
    assign w_reload = ((w_dec >= BASE_W) || ((BASE_W - w_dec) < MIN_W)) ? MIN_W : (BASE_W - w_dec);

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            r_state       <= ST_IDLE;
            r_start_q     <= 1'b0;
            r_health      <= 3'd0;
            r_level       <= 4'd0;
            r_kills       <= 8'd0;
            r_interval    <= 11'd0;
            r_hit_cnt     <= 11'd0;
            r_spawn_valid <= 1'b0;
            r_spawn_dir   <= 3'b000;
            r_rr_ptr      <= 2'd0;
        end else begin
            r_start_q <= start;
            if (w_start_edge && !w_active) begin
                r_state       <= ST_PLAY;
                r_health      <= HEALTH_W;
                r_level       <= 4'd0;
                r_kills       <= 8'd0;
                r_interval    <= BASE_W;
                r_hit_cnt     <= 11'd0;
                r_spawn_valid <= 1'b0;
                r_spawn_dir   <= 3'b000;
            end else if (w_active) begin
                // Reload wins over a coincident tick, so a fresh interval is never shortened.
                if (r_spawn_valid) begin
                    if (spawn_ready) begin
                        r_spawn_valid <= 1'b0;
                        r_interval    <= w_reload;
                    end
                end else if (r_interval == 11'd0) begin
                    if (w_found) begin
                        r_spawn_valid <= 1'b1;
                        r_spawn_dir   <= dir_onehot(w_idx);
                        r_rr_ptr      <= dir_next(w_idx);
                    end
                end else if (tick) begin
                    r_interval <= r_interval - 11'd1;
                end

                if ((r_state == ST_HIT) && tick) begin
                    if (r_hit_cnt <= 11'd1) begin
                        r_state   <= ST_PLAY;
                        r_hit_cnt <= 11'd0;
                    end else begin
                        r_hit_cnt <= r_hit_cnt - 11'd1;
                    end
                end

                if (enemy_kill) begin
                    if (r_kills == KILL_LAST) begin
                        r_kills <= 8'd0;
                        if (r_level != 4'd15) begin
                            r_level <= r_level + 4'd1;
                        end
                    end else begin
                        r_kills <= r_kills + 8'd1;
                    end
                end

                // Last assignment: a fatal hit overrides any spawn update in the same cycle.
                if (enemy_attack && (r_state == ST_PLAY)) begin
                    r_health <= r_health - 3'd1;
                    if (r_health == 3'd1) begin
                        r_state       <= ST_OVER;
                        r_spawn_valid <= 1'b0;
                    end else begin
                        r_state   <= ST_HIT;
                        r_hit_cnt <= HIT_W;
                    end
                end
            end
        end
    end

    assign spawn_valid = r_spawn_valid;
    assign spawn_dir   = r_spawn_dir;
    assign game_state  = r_state;
    assign health      = r_health;
    assign level       = r_level;

endmodule

// File: tb/tb_spawn_scheduler.sv
// Directed bench for spawn_scheduler: game flow, spawn timing, handshake, levels, game over.
module tb_spawn_scheduler;

    logic       ClkPort = 1'b0;
    logic       Reset;
    logic       tick;
    logic       start;
    logic [2:0] occupied;
    logic       enemy_attack;
    logic       enemy_kill;
    logic       spawn_ready;
    logic       spawn_valid;
    logic [2:0] spawn_dir;
    logic [1:0] game_state;
    logic [2:0] health;
    logic [3:0] level;

    int n_tests = 0;
    int n_fail  = 0;
    int n_ticks;

    spawn_scheduler dut (
        .ClkPort      (ClkPort),
        .Reset        (Reset),
        .tick         (tick),
        .start        (start),
        .occupied     (occupied),
        .enemy_attack (enemy_attack),
        .enemy_kill   (enemy_kill),
        .spawn_ready  (spawn_ready),
        .spawn_valid  (spawn_valid),
        .spawn_dir    (spawn_dir),
        .game_state   (game_state),
        .health       (health),
        .level        (level)
    );

    always #5 ClkPort = ~ClkPort;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge ClkPort);
    endtask

    task automatic tick_once();
        tick = 1'b1;
        @(negedge ClkPort);
        tick = 1'b0;
        @(negedge ClkPort);
    endtask

    task automatic pulse_attack();
        enemy_attack = 1'b1;
        @(negedge ClkPort);
        enemy_attack = 1'b0;
    endtask

    task automatic pulse_kill();
        enemy_kill = 1'b1;
        @(negedge ClkPort);
        enemy_kill = 1'b0;
    endtask

    // Ticks until spawn_valid is seen; n=0 when the bound expires.
    task automatic wait_spawn(input int max_ticks, output int n);
        n = 0;
        for (int i = 1; i <= max_ticks; i++) begin
            tick_once();
            if (spawn_valid) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset        = 1'b1;
        tick         = 1'b0;
        start        = 1'b0;
        occupied     = 3'b000;
        enemy_attack = 1'b0;
        enemy_kill   = 1'b0;
        spawn_ready  = 1'b1;
        cyc(3);
        chk("rst_state",  32'(game_state), 32'd0);
        chk("rst_valid",  32'(spawn_valid), 32'd0);
        chk("rst_dir",    32'(spawn_dir), 32'd0);
        chk("rst_health", 32'(health), 32'd0);
        chk("rst_level",  32'(level), 32'd0);
        Reset = 1'b0;
        cyc(2);
        chk("idle_hold", 32'(game_state), 32'd0);

        start = 1'b1;
        cyc(1);
        chk("start_state",  32'(game_state), 32'd1);
        chk("start_health", 32'(health), 32'd5);
        chk("start_level",  32'(level), 32'd0);

        repeat (199) tick_once();
        chk("spawn_before_200", 32'(spawn_valid), 32'd0);
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        chk("spawn_at_zero", 32'(spawn_valid), 32'd0);
        cyc(1);
        chk("spawn_rise",   32'(spawn_valid), 32'd1);
        chk("spawn_onehot", 32'($onehot(spawn_dir)), 32'd1);
        cyc(1);
        chk("spawn_accepted", 32'(spawn_valid), 32'd0);
        wait_spawn(20, n_ticks);
        chk("single_pulse", 32'(n_ticks), 32'd0);

        occupied = 3'b111;
        wait_spawn(250, n_ticks);
        chk("blocked_no_spawn", 32'(n_ticks), 32'd0);
        cyc(3);
        chk("blocked_valid", 32'(spawn_valid), 32'd0);
        occupied    = 3'b101;
        spawn_ready = 1'b0;
        cyc(1);
        chk("freed_valid", 32'(spawn_valid), 32'd1);
        chk("freed_dir",   32'(spawn_dir), 32'b010);

        occupied = 3'b000;
        for (int i = 0; i < 30; i++) begin
            tick = i[0];
            cyc(1);
            chk("hold_valid", 32'(spawn_valid), 32'd1);
            chk("hold_dir",   32'(spawn_dir), 32'b010);
        end
        tick        = 1'b0;
        spawn_ready = 1'b1;
        cyc(1);
        chk("release_valid", 32'(spawn_valid), 32'd0);
        wait_spawn(400, n_ticks);
        chk("interval_lvl0", 32'(n_ticks), 32'd200);
        cyc(1);

        pulse_attack();
        chk("hit_health", 32'(health), 32'd4);
        chk("hit_state",  32'(game_state), 32'd2);
        start = 1'b0;
        cyc(1);
        start = 1'b1;
        cyc(1);
        chk("start_ign_hit", 32'(health), 32'd4);
        repeat (10) tick_once();
        pulse_attack();
        chk("hit_ignored_health", 32'(health), 32'd4);
        chk("hit_ignored_state",  32'(game_state), 32'd2);
        repeat (89) tick_once();
        chk("hit_99", 32'(game_state), 32'd2);
        tick_once();
        chk("hit_100_play", 32'(game_state), 32'd1);
        start = 1'b0;
        cyc(1);
        start = 1'b1;
        cyc(1);
        chk("start_ign_play", 32'(health), 32'd4);

        for (int i = 1; i <= 8; i++) begin
            pulse_kill();
            cyc(1);
            if (i == 4) chk("level_after_4", 32'(level), 32'd1);
        end
        chk("level_after_8", 32'(level), 32'd2);
        wait_spawn(400, n_ticks);
        chk("sync_lvl2", 32'(spawn_valid), 32'd1);
        cyc(1);
        wait_spawn(400, n_ticks);
        chk("interval_lvl2", 32'(n_ticks), 32'd180);
        cyc(1);

        repeat (52) begin
            pulse_kill();
            cyc(1);
        end
        chk("level_after_60", 32'(level), 32'd15);
        repeat (4) begin
            pulse_kill();
            cyc(1);
        end
        chk("level_saturate", 32'(level), 32'd15);
        wait_spawn(400, n_ticks);
        chk("sync_lvl15", 32'(spawn_valid), 32'd1);
        cyc(1);
        wait_spawn(400, n_ticks);
        chk("interval_min", 32'(n_ticks), 32'd50);
        cyc(1);

        repeat (3) begin
            pulse_attack();
            repeat (100) tick_once();
        end
        chk("health_one", 32'(health), 32'd1);
        chk("play_again", 32'(game_state), 32'd1);

        spawn_ready = 1'b0;
        wait_spawn(400, n_ticks);
        chk("pending_valid", 32'(spawn_valid), 32'd1);
        enemy_attack = 1'b1;
        enemy_kill   = 1'b1;
        cyc(1);
        enemy_attack = 1'b0;
        enemy_kill   = 1'b0;
        chk("over_state",  32'(game_state), 32'd3);
        chk("over_health", 32'(health), 32'd0);
        chk("over_valid",  32'(spawn_valid), 32'd0);
        chk("over_level",  32'(level), 32'd15);
        spawn_ready = 1'b1;
        repeat (5) tick_once();
        pulse_attack();
        cyc(1);
        chk("over_frozen_health", 32'(health), 32'd0);
        chk("over_frozen_state",  32'(game_state), 32'd3);
        chk("over_frozen_valid",  32'(spawn_valid), 32'd0);

        start = 1'b0;
        cyc(1);
        start = 1'b1;
        cyc(1);
        chk("restart_state",  32'(game_state), 32'd1);
        chk("restart_health", 32'(health), 32'd5);
        chk("restart_level",  32'(level), 32'd0);
        chk("restart_valid",  32'(spawn_valid), 32'd0);
        wait_spawn(400, n_ticks);
        chk("restart_interval", 32'(n_ticks), 32'd200);
        cyc(1);

        pulse_attack();
        chk("pre_reset_health", 32'(health), 32'd4);
        #2;
        Reset = 1'b1;
        #1;
        chk("async_rst_state",  32'(game_state), 32'd0);
        chk("async_rst_health", 32'(health), 32'd0);
        chk("async_rst_level",  32'(level), 32'd0);
        chk("async_rst_valid",  32'(spawn_valid), 32'd0);
        cyc(2);
        Reset = 1'b0;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
